// File: rtl/imem_fetch_server.sv
// Byte-wide instruction memory with a sequential 10-byte window read engine.
// A byte-write load port fills memory while the engine is not busy.
module imem_fetch_server #(
   parameter int MEM_BYTES = 20481,
   parameter int WIN_BYTES = 10
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_ld_en,
   input  logic [63:0]            i_ld_addr,
   input  logic [7:0]             i_ld_data,
   input  logic                   i_req,
   input  logic [63:0]            i_req_pc,
   output logic                   o_busy,
   output logic                   o_instr_valid,
   output logic [8*WIN_BYTES-1:0] o_instr,
   output logic                   o_mem_error
);

   // state | meaning
   // IDLE  | waiting for a request; load port active
   // READ  | one byte per cycle into the assembly register
   // DONE  | window complete, instr_valid pulse; accepts a new request

   localparam int AW = $clog2(MEM_BYTES);
   localparam int WW = 8 * WIN_BYTES;

   typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

   state_t              r_state, w_state_next;
   logic [7:0]          r_mem [0:MEM_BYTES-1];
   logic [63:0]         r_pc;
   logic [3:0]          r_cnt;
   logic [WW-1:0]       r_asm;
   logic                r_err;
   logic [WW-1:0]       r_instr;
   logic                r_merr;

   logic                w_accept;
   logic                w_last;
   logic [63:0]         w_addr;
   logic                w_in_range;
   logic [7:0]          w_byte;
   logic [WW-1:0]       w_asm_next;
   logic                w_err_next;
   logic                w_ld_ok;

   assign w_accept   = (r_state != READ) && i_req;
   assign w_last     = (r_cnt == 4'(WIN_BYTES - 1));
   assign w_addr     = r_pc + 64'(r_cnt);
   assign w_in_range = (w_addr < 64'(MEM_BYTES));
   assign w_byte     = w_in_range ? r_mem[w_addr[AW-1:0]] : 8'h00;
   assign w_asm_next = {r_asm[WW-9:0], w_byte};
   assign w_err_next = r_err | ~w_in_range;
   assign w_ld_ok    = i_ld_en && (r_state != READ) && (i_ld_addr < 64'(MEM_BYTES));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (i_req) w_state_next = READ;
         READ:    if (w_last) w_state_next = DONE;
         DONE:    w_state_next = i_req ? READ : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc    <= '0;
         r_cnt   <= '0;
         r_asm   <= '0;
         r_err   <= 1'b0;
         r_instr <= '0;
         r_merr  <= 1'b0;
      end else if (w_accept) begin
         r_pc  <= i_req_pc;
         r_cnt <= '0;
         r_asm <= '0;
         r_err <= 1'b0;
      end else if (r_state == READ) begin
         r_asm <= w_asm_next;
         r_err <= w_err_next;
         r_cnt <= r_cnt + 4'd1;
         if (w_last) begin
            r_instr <= w_asm_next;
            r_merr  <= w_err_next;
         end
      end
   end

   // Memory is deliberately outside the reset domain so programs survive reset.
   always_ff @(posedge i_clk) begin
      if (w_ld_ok) r_mem[i_ld_addr[AW-1:0]] <= i_ld_data;
   end

   assign o_busy        = (r_state == READ);
   assign o_instr_valid = (r_state == DONE);
   assign o_instr       = r_instr;
   assign o_mem_error   = r_merr;

endmodule
